// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader writing big-endian words into instruction memory
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {
        IDLE, HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR
    } state_t;

    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

    state_t            state;
    logic [15:0]       n_words;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_idx;
    logic [23:0]       wbuf;
    logic [7:0]        csum;
    logic              accept;
    logic [15:0]       n_next;
    logic              last_word;

    assign accept    = s_valid && s_ready;
    assign n_next    = {n_words[15:8], s_data};
    assign last_word = (32'(word_idx) == (32'(n_words) - 32'd1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            s_ready  <= 1'b0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
            cpu_hold <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            n_words  <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            wbuf     <= '0;
            csum     <= '0;
        end else begin
            im_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state    <= HDR_HI;
                        s_ready  <= 1'b1;
                        busy     <= 1'b1;
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        n_words  <= '0;
                        word_idx <= '0;
                        byte_idx <= '0;
                        csum     <= '0;
                    end
                end
                HDR_HI: begin
                    if (accept) begin
                        n_words[15:8] <= s_data;
                        state         <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (accept) begin
                        n_words[7:0] <= s_data;
                        if (32'(n_next) > CAPACITY) begin
                            state   <= ERR;
                            s_ready <= 1'b0;
                            busy    <= 1'b0;
                            err     <= 1'b1;
                        end else if (n_next == 16'd0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        csum     <= csum ^ s_data;
                        byte_idx <= byte_idx + 2'd1;
                        wbuf     <= {wbuf[15:0], s_data};
                        if (byte_idx == 2'd3) begin
                            im_we    <= 1'b1;
                            im_addr  <= word_idx;
                            im_wdata <= {wbuf, s_data};
                            // wraps to zero after a full-capacity load; never read again
                            word_idx <= word_idx + 1'b1;
                            if (last_word) begin
                                state <= CSUM;
                            end
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                        if (s_data == csum) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule
